// File: rtl/pipe_pkg.sv
// pipe_pkg: shared definitions for the pipeline sequencing controller.
//   - MIPS exception codes delivered by the MEM stage
//   - stall vector encodings (bit0 PC .. bit5 WB)
//   - controller FSM state type
package pipe_pkg;

  localparam logic [31:0] EXC_INT  = 32'h0000_0001;
  localparam logic [31:0] EXC_SYS  = 32'h0000_0008;
  localparam logic [31:0] EXC_RI   = 32'h0000_000a;
  localparam logic [31:0] EXC_OV   = 32'h0000_000c;
  localparam logic [31:0] EXC_TR   = 32'h0000_000d;
  localparam logic [31:0] EXC_ERET = 32'h0000_000e;

  localparam logic [5:0] STALL_MEM  = 6'b011111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_IF   = 6'b000011;
  localparam logic [5:0] STALL_NONE = 6'b000000;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_SQUASH = 1'b1
  } pipe_state_e;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: W-bit up counter that sticks at all-ones instead of wrapping.
// Ports:
//   clk  - clock, counts on rising edge
//   rst  - asynchronous active-low clear
//   inc  - count enable for this edge
//   q    - current count
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (inc && (q_q != {W{1'b1}})) begin
      q_d = q_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline sequencing controller for the five-stage MIPS core.
// Merges per-stage stall requests into the stall vector, converts the MEM
// stage exception word into a one-cycle flush plus redirect PC, and blocks
// exceptions in the cycle after a flush (SQUASH).
// Optional build macro: PIPE_PERF_CNT_EN enables saturating stall/flush
// performance counters; without it both counter outputs read 0.
// Ports:
//   clk, rst (async active-low)
//   stallreq_if/id/ex/mem - per-stage stall requests
//   excepttype_i          - MEM stage exception word, 0 = none
//   cp0_epc_i             - forwarded EPC, target of ERET
//   stall[5:0]            - bit0 PC .. bit5 WB hold
//   flush                 - clear all pipeline registers this cycle
//   new_pc                - redirect target while flush=1, else 0
//   stall_cycles          - cycles with stall[0]=1 (macro only)
//   flush_count           - flush pulses (macro only)
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
  parameter int          CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_if,
  input  logic             stallreq_id,
  input  logic             stallreq_ex,
  input  logic             stallreq_mem,
  input  logic [31:0]      excepttype_i,
  input  logic [31:0]      cp0_epc_i,
  output logic [5:0]       stall,
  output logic             flush,
  output logic [31:0]      new_pc,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  pipe_state_e state_q;
  pipe_state_e state_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Outputs are held at zero while reset is asserted, independent of inputs.
  always_comb begin
    stall   = STALL_NONE;
    flush   = 1'b0;
    new_pc  = 32'h0;
    state_d = ST_RUN;
    if (rst) begin
      unique case (state_q)
        ST_RUN: begin
          if (excepttype_i != 32'h0) begin
            // Exception wins over every stall so the flush is not delayed.
            flush   = 1'b1;
            new_pc  = (excepttype_i == EXC_ERET) ? cp0_epc_i : EXC_VECTOR;
            state_d = ST_SQUASH;
          end else if (stallreq_mem) begin
            stall = STALL_MEM;
          end else if (stallreq_ex) begin
            stall = STALL_EX;
          end else if (stallreq_id) begin
            stall = STALL_ID;
          end else if (stallreq_if) begin
            stall = STALL_IF;
          end
        end
        ST_SQUASH: begin
          // Downstream registers were just cleared, so their requests and the
          // stale exception word are meaningless; only fetch can still stall.
          if (stallreq_if) begin
            stall = STALL_IF;
          end
          state_d = ST_RUN;
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

`ifdef PIPE_PERF_CNT_EN
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (stall[0]),
    .q   (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (flush),
    .q   (flush_count)
  );
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule
